pdm_array_sequencer: RTL

Controller for the microphone array's bank of loadPDM channels. It generates the common decimation strobe that all loadPDM instances share. After each strobe it waits a fixed number of cycles, then snapshots every channel's rising-edge (R) and falling-edge (F) sample. It streams the snapshot out as one word per cycle over a valid/ready interface to the downstream beamformer/logger.

---
 rtl/pdm_array_pkg.sv | 19 +
 rtl/pdm_strobe_gen.sv | 41 ++++
 rtl/pdm_array_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pdm_array_pkg.sv
// Shared definitions for the PDM array sequencer: FSM encoding,
// default sizing constants and the R/F edge encoding used on o_edge.
package pdm_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  localparam int C_WIDTH_DEF    = 12;
  localparam int C_CHANNELS_DEF = 4;
  localparam int C_DECIM_DEF    = 64;

  // Word index bit 0 selects the sample edge: R words first, then F.
  localparam logic EDGE_R = 1'b0;
  localparam logic EDGE_F = 1'b1;

endpackage

// File: rtl/pdm_strobe_gen.sv
// Decimation strobe generator: free-running 0..c_decim-1 counter while
// enabled, registered one-cycle strobe after the terminal count.
module pdm_strobe_gen #(
  parameter int c_decim = 64
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_strobe
);

  localparam int CW = (c_decim > 2) ? $clog2(c_decim) : 1;
  localparam logic [CW-1:0] LAST = CW'(c_decim - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          strobe_q, strobe_d;

  // Next count and strobe; disabling clears the count and suppresses the strobe.
  always_comb begin
    cnt_d    = '0;
    strobe_d = 1'b0;
    if (i_enable) begin
      strobe_d = (cnt_q == LAST);
      cnt_d    = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter and strobe registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign o_strobe = strobe_q;

endmodule

// File: rtl/pdm_array_sequencer.sv
// PDM array sequencer: issues the shared decimation strobe, snapshots all
// channel R/F samples c_latency cycles later, then streams the snapshot
// one word per cycle.
//
// Handshake: o_valid is high for every cycle a word is presented; a word is
// consumed on a rising edge where o_valid & i_ready are both high, and while
// o_valid is high without i_ready the word and its sideband stay unchanged.
module pdm_array_sequencer
  import pdm_array_pkg::*;
#(
  parameter int c_width    = C_WIDTH_DEF,
  parameter int c_channels = C_CHANNELS_DEF,
  parameter int c_chanBits = 2,
  parameter int c_decim    = C_DECIM_DEF,
  parameter int c_latency  = 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_enable,
  output logic                          o_strobe,
  input  logic [c_channels*c_width-1:0] i_dataR,
  input  logic [c_channels*c_width-1:0] i_dataF,
  output logic [c_width-1:0]            o_data,
  output logic [c_chanBits-1:0]         o_chan,
  output logic                          o_edge,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_frameStart,
  output logic                          o_overrun,
  output logic                          o_busy,
  output logic [1:0]                    o_dbg_state
);

  localparam int NWORDS = 2 * c_channels;
  localparam int KW     = $clog2(NWORDS);
  localparam int WCW    = (c_latency > 1) ? $clog2(c_latency) : 1;
  localparam logic [KW-1:0]  LAST_K    = KW'(NWORDS - 1);
  localparam logic [WCW-1:0] WAIT_INIT = WCW'((c_latency > 0) ? c_latency - 1 : 0);

  state_e                          state_q, state_d;
  logic [KW-1:0]                   k_q, k_d;
  logic [WCW-1:0]                  wait_q, wait_d;
  logic                            ovr_q, ovr_d;
  logic [c_channels*c_width-1:0]   snap_r_q, snap_r_d;
  logic [c_channels*c_width-1:0]   snap_f_q, snap_f_d;

  logic          strobe;
  logic          accept;
  logic          last_accept;
  logic          capture;
  logic [KW-1:0] ch_idx;
  logic          word_edge;
  logic [c_width-1:0] word_data;

  pdm_strobe_gen #(
    .c_decim (c_decim)
  ) u_strobe_gen (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .o_strobe (strobe)
  );

  // Next-state logic: strobe scheduling, word advance, overrun and capture.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wait_d      = wait_q;
    ovr_d       = ovr_q;
    snap_r_d    = snap_r_q;
    snap_f_d    = snap_f_q;
    capture     = 1'b0;
    accept      = (state_q == ST_SEND) && i_ready;
    last_accept = accept && (k_q == LAST_K);

    case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          if (c_latency == 0) begin
            capture = 1'b1;
            state_d = ST_SEND;
            k_d     = '0;
          end else begin
            state_d = ST_WAIT;
            wait_d  = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        // A strobe here would need a second capture slot; drop it.
        if (strobe) ovr_d = 1'b1;
        if (wait_q == '0) begin
          capture = 1'b1;
          state_d = ST_SEND;
          k_d     = '0;
        end else begin
          wait_d = wait_q - WCW'(1);
        end
      end
      ST_SEND: begin
        // Only a strobe coinciding with the final accept can start a new frame.
        if (strobe && !last_accept) ovr_d = 1'b1;
        if (last_accept) begin
          k_d = '0;
          if (strobe) begin
            if (c_latency == 0) begin
              capture = 1'b1;
              state_d = ST_SEND;
            end else begin
              state_d = ST_WAIT;
              wait_d  = WAIT_INIT;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else if (accept) begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      snap_r_d = i_dataR;
      snap_f_d = i_dataF;
    end
  end

  // State, index, overrun and snapshot registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      wait_q   <= '0;
      ovr_q    <= 1'b0;
      snap_r_q <= '0;
      snap_f_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      wait_q   <= wait_d;
      ovr_q    <= ovr_d;
      snap_r_q <= snap_r_d;
      snap_f_q <= snap_f_d;
    end
  end

  // Output mux: word k is channel k>>1, edge k[0].
  always_comb begin
    ch_idx    = k_q >> 1;
    word_edge = k_q[0];
    word_data = (word_edge == EDGE_F) ? snap_f_q[ch_idx*c_width +: c_width]
                                      : snap_r_q[ch_idx*c_width +: c_width];
  end

  assign o_strobe     = strobe;
  assign o_valid      = (state_q == ST_SEND);
  assign o_data       = o_valid ? word_data : '0;
  assign o_chan       = o_valid ? c_chanBits'(ch_idx) : '0;
  assign o_edge       = o_valid & word_edge;
  assign o_frameStart = o_valid && (k_q == '0);
  assign o_overrun    = ovr_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_dbg_state  = state_q;

endmodule
